// File: rtl/mono_conf_pkg.sv
// Shared definitions for the per-column pixel configuration shift register:
// field indices, chain state encoding and the one-hot mask helper.
package mono_conf_pkg;

    localparam int FLD_TRIM0  = 0;
    localparam int FLD_TRIM1  = 1;
    localparam int FLD_TRIM2  = 2;
    localparam int FLD_TRIM3  = 3;
    localparam int FLD_INJ    = 4;
    localparam int FLD_MON    = 5;
    localparam int FLD_PREAMP = 6;
    localparam int NFIELD_DEF = 7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFTING = 2'd1,
        ARMED    = 2'd2
    } conf_state_t;

    // True when exactly one bit of the (zero-extended) mask is set.
    function automatic logic onehot(input logic [31:0] mask);
        return (mask != 32'd0) && ((mask & (mask - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/mono_conf_bank.sv
// One configuration field register: NPIX-wide, loaded as a whole when ld is high.
module mono_conf_bank #(
    parameter int W = 129
) (
    input  logic         SR_CLK,
    input  logic         RstInt,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next value: capture on load, otherwise hold.
    always_comb begin
        if (ld) begin
            q_d = d;
        end else begin
            q_d = q_q;
        end
    end

    // Field storage with asynchronous clear.
    always_ff @(posedge SR_CLK or posedge RstInt) begin
        if (RstInt) begin
            q_q <= {W{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/mono_conf_sr.sv
// Per-column configuration chain feeding NFIELD banks, with bit counter, load guard,
// readback and sticky error. Optional framing parity: MONO_CONF_SR_PARITY_EN.
module mono_conf_sr
    import mono_conf_pkg::*;
#(
    parameter int NPIX      = 129,
    parameter int NFIELD    = NFIELD_DEF,
    parameter int STRICT_LD = 1,
    parameter int CW        = $clog2(NPIX + 2)
) (
    input  logic                   SR_CLK,
    input  logic                   RstInt,
    input  logic                   SR_DATA_IN,
    input  logic                   SR_EN,
    input  logic                   LD,
    input  logic                   RB,
    input  logic [NFIELD-1:0]      FIELD_MASK,
    output logic                   SR_DATA_OUT,
    output logic [NFIELD*NPIX-1:0] CFG,
    output logic                   ARMED,
    output logic [CW-1:0]          BIT_CNT,
    output logic                   ERR
);

`ifdef MONO_CONF_SR_PARITY_EN
    localparam int CHAIN_W = NPIX + 1;
`else
    localparam int CHAIN_W = NPIX;
`endif
    // A full frame is exactly one chain's worth of bits.
    localparam logic [CW-1:0] FULLCNT = CW'(CHAIN_W);

    logic [CHAIN_W-1:0]     chain_q, chain_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    conf_state_t            state_q, state_d;
    logic                   armed_q, armed_d;
    logic                   err_q, err_d;
    logic [NFIELD-1:0]      bank_ld;
    logic [NFIELD*NPIX-1:0] cfg_w;
    logic [NPIX-1:0]        frame;
    logic [NPIX-1:0]        rb_field;
    logic [CHAIN_W-1:0]     rb_chain;
    logic                   rb_ok;
    logic                   ld_ok;
    logic                   shift_par_ok;

    // Data bits sit at the top of the chain; with parity, stage 0 holds the parity bit.
    assign frame = chain_q[CHAIN_W-1 -: NPIX];
    assign rb_ok = onehot(32'(FIELD_MASK));

`ifdef MONO_CONF_SR_PARITY_EN
    logic p_q, p_d;
    assign rb_chain     = {rb_field, ^rb_field};
    assign shift_par_ok = ~(p_q ^ SR_DATA_IN);
    assign ld_ok        = ((STRICT_LD != 0) ? armed_q : 1'b1) && !((cnt_q == FULLCNT) && p_q);
`else
    assign rb_chain     = rb_field;
    assign shift_par_ok = 1'b1;
    assign ld_ok        = (STRICT_LD != 0) ? armed_q : 1'b1;
`endif

    assign cnt_inc = (cnt_q == FULLCNT) ? cnt_q : (cnt_q + CW'(1'b1));

    // Select the readback field; the mask is one-hot whenever this is used.
    always_comb begin
        rb_field = {NPIX{1'b0}};
        for (int f = 0; f < NFIELD; f++) begin
            if (FIELD_MASK[f]) begin
                rb_field = rb_field | cfg_w[f*NPIX +: NPIX];
            end else begin
                rb_field = rb_field;
            end
        end
    end

    // Command decode: LD&RB conflict, then RB, then LD, then shift.
    always_comb begin
        chain_d = chain_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        err_d   = err_q;
        bank_ld = {NFIELD{1'b0}};
`ifdef MONO_CONF_SR_PARITY_EN
        p_d     = p_q;
`endif
        if (LD && RB) begin
            err_d = 1'b1;
        end else if (RB) begin
            if (rb_ok) begin
                chain_d = rb_chain;
                cnt_d   = {CW{1'b0}};
                state_d = mono_conf_pkg::IDLE;
`ifdef MONO_CONF_SR_PARITY_EN
                p_d     = 1'b0;
`endif
            end else begin
                err_d = 1'b1;
            end
        end else if (LD) begin
            if (ld_ok) begin
                bank_ld = FIELD_MASK;
                cnt_d   = {CW{1'b0}};
                state_d = mono_conf_pkg::IDLE;
`ifdef MONO_CONF_SR_PARITY_EN
                p_d     = 1'b0;
`endif
            end else begin
                err_d = 1'b1;
            end
        end else if (SR_EN) begin
            chain_d = {chain_q[CHAIN_W-2:0], SR_DATA_IN};
            cnt_d   = cnt_inc;
`ifdef MONO_CONF_SR_PARITY_EN
            p_d     = p_q ^ SR_DATA_IN;
`endif
            if ((cnt_inc == FULLCNT) && shift_par_ok) begin
                state_d = mono_conf_pkg::ARMED;
            end else begin
                state_d = mono_conf_pkg::SHIFTING;
            end
        end else begin
            chain_d = chain_q;
        end
        armed_d = (state_d == mono_conf_pkg::ARMED);
    end

    // Chain, counter, state and status registers.
    always_ff @(posedge SR_CLK or posedge RstInt) begin
        if (RstInt) begin
            chain_q <= {CHAIN_W{1'b0}};
            cnt_q   <= {CW{1'b0}};
            state_q <= mono_conf_pkg::IDLE;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef MONO_CONF_SR_PARITY_EN
            p_q     <= 1'b0;
`endif
        end else begin
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            armed_q <= armed_d;
            err_q   <= err_d;
`ifdef MONO_CONF_SR_PARITY_EN
            p_q     <= p_d;
`endif
        end
    end

    for (genvar f = 0; f < NFIELD; f++) begin : g_bank
        mono_conf_bank #(
            .W (NPIX)
        ) u_bank (
            .SR_CLK (SR_CLK),
            .RstInt (RstInt),
            .ld     (bank_ld[f]),
            .d      (frame),
            .q      (cfg_w[f*NPIX +: NPIX])
        );
    end

    assign SR_DATA_OUT = chain_q[CHAIN_W-1];
    assign CFG         = cfg_w;
    assign ARMED       = armed_q;
    assign BIT_CNT     = cnt_q;
    assign ERR         = err_q;

endmodule

// File: doc/mono_conf_sr.md
Name: mono_conf_sr

Overview:
- Parametrised successor to the per-pixel configuration chain.
- One shift-register bit per pixel, NPIX deep, feeds NFIELD registered configuration banks. Banks are loaded selectively by field mask.
- Adds a shift-bit counter, a load-armed guard, field readback into the chain, and a sticky error flag.
- Instantiated once per column; banks drive pixel TRIM/INJECT/MONITOR/PREAMP enables.

Parameters:
- NPIX, 129, chain length (pixels per column).
- NFIELD, 7, number of config banks (4 trim, inject, monitor, preamp).
- STRICT_LD, 1, 1 = LD rejected unless chain armed; 0 = LD always accepted.
- CW, $clog2(NPIX+2), bit-counter width.

Ports:
- SR_CLK  in  1  configuration clock; all state on rising edge.
- RstInt  in  1  reset, asynchronous, active-high.
- SR_DATA_IN  in  1  serial data in.
- SR_EN  in  1  shift enable.
- LD  in  1  load strobe, sampled on SR_CLK.
- RB  in  1  readback strobe, sampled on SR_CLK.
- FIELD_MASK  in  NFIELD  bank select; LD uses any mask, RB requires one-hot.
- SR_DATA_OUT  out  1  serial out = chain bit NPIX-1.
- CFG  out  NFIELD*NPIX  bank contents; field f occupies [f*NPIX +: NPIX].
- ARMED  out  1  chain holds a complete frame.
- BIT_CNT  out  CW  bits shifted since last LD/RB; saturates.
- ERR  out  1  sticky error.

Behaviour:
- Reset (RstInt=1, async): chain=0, CFG=0, BIT_CNT=0, ARMED=0, ERR=0, state=IDLE, SR_DATA_OUT=0.
- Command priority per edge:
  - LD&RB both high → ERR<=1, no other change.
  - Else RB, then LD, then SR_EN.
- Shift (SR_EN=1, no LD/RB):
  - chain <= {chain[NPIX-2:0], SR_DATA_IN}.
  - BIT_CNT <= min(BIT_CNT+1, FULLCNT), where FULLCNT=NPIX (NPIX+1 with parity feature).
  - SR_DATA_OUT follows chain[NPIX-1], so 1-cycle latency per stage, NPIX cycles in-to-out.
- States:
  - IDLE (BIT_CNT=0): SR_EN → SHIFTING.
  - SHIFTING: BIT_CNT reaches FULLCNT → ARMED. In ARMED, further shifts keep it ARMED (saturated count); the frame is the last NPIX bits.
  - LD or RB accepted → IDLE.
- ARMED output = (state==ARMED), registered.
- LD:
  - Rejected when STRICT_LD=1 and not ARMED: ERR<=1, CFG unchanged, counter unchanged.
  - Accepted: CFG field f <= chain for every FIELD_MASK[f]=1; others hold. BIT_CNT<=0.
  - FIELD_MASK=0 is a no-op load; counter is still cleared, no error.
- RB:
  - FIELD_MASK must be one-hot, else ERR<=1 with no change.
  - Accepted: chain <= CFG field f, BIT_CNT<=0, state IDLE. The next NPIX shifts present bit NPIX-1 first on SR_DATA_OUT.
- SR_EN during LD edge: ignored; the load uses the pre-edge chain.
- ERR clears only on RstInt.
- RstInt mid-shift or mid-load: everything reset immediately; no partial CFG update.

Optional Feature:
- Macro MONO_CONF_SR_PARITY_EN.
- When defined:
  - Running parity register P toggles with each shifted-in 1; cleared on LD/RB/reset.
  - FULLCNT=NPIX+1: the frame is NPIX data bits followed by an even-parity bit. The chain is NPIX+1 deep; SR_DATA_OUT taps stage NPIX.
  - ARMED additionally requires P==0.
  - LD when BIT_CNT==FULLCNT but P==1 → rejected, ERR<=1, regardless of STRICT_LD.
  - RB loads the parity bit as stage 0 so readback is re-loadable.
- When undefined: no P register, FULLCNT=NPIX, chain NPIX deep.

Decomposition:
- Package mono_conf_pkg:
  - Field index constants FLD_TRIM0..FLD_TRIM3=0..3, FLD_INJ=4, FLD_MON=5, FLD_PREAMP=6, NFIELD_DEF=7.
  - State enum typedef conf_state_t {IDLE, SHIFTING, ARMED}.
  - Function onehot(mask).
- One sub-module, mono_conf_bank: a single NPIX-wide field register with load enable and async reset. It is instantiated NFIELD times via generate.

Test Plan (NPIX=8, NFIELD=3, STRICT_LD=1, no macro unless noted):
- Shift 0xA5 MSB-first (8 edges), LD mask=3'b010 → CFG[15:8]=0xA5, CFG[7:0]=0, CFG[23:16]=0, BIT_CNT=0, ARMED=0, ERR=0.
- Shift 5 bits, LD mask=3'b001 → CFG unchanged, ERR=1, BIT_CNT=5. Then 3 more shifts → ARMED=1.
- After the first test, RB mask=3'b010, then 8 shifts with SR_DATA_IN=0 → SR_DATA_OUT sequence 1,0,1,0,0,1,0,1. RB mask=3'b011 → ERR=1.
- LD and RB high on the same edge with ARMED=1 → ERR=1, CFG and chain unchanged.
- RstInt pulsed mid-way between SR_CLK edges after 4 shifts → all outputs 0 immediately, without waiting for an edge.
- MONO_CONF_SR_PARITY_EN: shift 0xA5 then parity 0 (9 bits) → ARMED=1 and LD accepted. Shift 0xA5 then parity 1 → ARMED=0, LD sets ERR=1, CFG unchanged.
